// File: rtl/debounced_updown_display.sv
// debounced_updown_display: debounced push-switch BCD up/down counter with multiplexed 7-segment display
module debounced_updown_display #(
  parameter int DIGITS = 8,
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE = 10000000,
  parameter int REFRESH_TICKS = 100000,
  parameter bit BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw,
  input  logic                  uphdnl,
  input  logic                  wrap_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   count,
  output logic                  limit
);
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(REFRESH_TICKS + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;

  logic [1:0]           sw_q, dir_q, wrap_q;
  logic                 sw_s, dir_s, wrap_s;
  logic                 db;
  logic [DBW-1:0]       db_cnt;
  logic [1:0]           state;
  logic [TW-1:0]        tmr;
  logic                 step;
  logic [4*DIGITS-1:0]  nxt;
  logic                 cout;
  logic [RW-1:0]        rcnt;
  logic [IW-1:0]        idx, idx_n;
  logic [3:0]           dig;
  logic                 blank;
  logic [6:0]           enc;

  assign sw_s = sw_q[1];
  assign dir_s = dir_q[1];
  assign wrap_s = wrap_q[1];

  // two-flop synchronisers for the raw board inputs
  always_ff @(posedge clk)
    if (!reset) begin
      sw_q <= '0;
      dir_q <= '0;
      wrap_q <= '0;
    end else begin
      sw_q <= {sw_q[0], sw};
      dir_q <= {dir_q[0], uphdnl};
      wrap_q <= {wrap_q[0], wrap_en};
    end

  // accept a new switch level only after it has disagreed with db long enough
  always_ff @(posedge clk)
    if (!reset) begin
      db <= 1'b0;
      db_cnt <= '0;
    end else if (sw_s == db)
      db_cnt <= '0;
    else if (db_cnt == DBW'(DEBOUNCE_TICKS)) begin
      db <= sw_s;
      db_cnt <= '0;
    end else
      db_cnt <= db_cnt + 1'b1;

  // a step fires on the press, after the repeat delay, then at the repeat rate
  always_comb
    step = db && (state == IDLE ||
                  (state == HOLD && REPEAT_DELAY > 0 && tmr == TW'(REPEAT_DELAY - 1)) ||
                  (state == REPEAT && tmr == TW'(REPEAT_RATE - 1)));

  // press / hold / repeat sequencing with a shared hold timer
  always_ff @(posedge clk)
    if (!reset || !db) begin
      state <= IDLE;
      tmr <= '0;
    end else if (step) begin
      state <= state == IDLE ? HOLD : REPEAT;
      tmr <= '0;
    end else
      tmr <= tmr + 1'b1;

  // BCD ripple increment/decrement; cout set when every digit was at the limit
  always_comb begin
    nxt = count;
    cout = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nxt[4*i+:4] = !cout ? count[4*i+:4] :
                    dir_s ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) :
                            (count[4*i+:4] == 4'd0 ? 4'd9 : count[4*i+:4] - 4'd1);
      cout = cout && count[4*i+:4] == (dir_s ? 4'd9 : 4'd0);
    end
  end

  // count register: wrap or saturate at the limits, flagging either with limit
  always_ff @(posedge clk)
    if (!reset) begin
      count <= '0;
      limit <= 1'b0;
    end else begin
      limit <= step && cout;
      if (step && (!cout || wrap_s))
        count <= nxt;
    end

  // next scan index and the segment pattern of the digit it selects
  always_comb begin
    idx_n = rcnt == RW'(REFRESH_TICKS - 1) ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
    dig = count[{idx_n, 2'b00} +: 4];
    blank = BLANK_LZ && idx_n != '0 && (count >> {idx_n, 2'b00}) == '0;
    case (dig)
      4'd0: enc = 7'b0000001;
      4'd1: enc = 7'b1001111;
      4'd2: enc = 7'b0010010;
      4'd3: enc = 7'b0000110;
      4'd4: enc = 7'b1001100;
      4'd5: enc = 7'b0100100;
      4'd6: enc = 7'b0100000;
      4'd7: enc = 7'b0001111;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0000100;
      default: enc = 7'b1111111;
    endcase
  end

  // registered display scan so seg and an switch on the same edge
  always_ff @(posedge clk)
    if (!reset) begin
      rcnt <= '0;
      idx <= '0;
      an <= ~DIGITS'(1);
      seg <= 7'b0000001;
    end else begin
      rcnt <= rcnt == RW'(REFRESH_TICKS - 1) ? '0 : rcnt + 1'b1;
      idx <= idx_n;
      an <= ~(DIGITS'(1) << idx_n);
      seg <= blank ? 7'b1111111 : enc;
    end
endmodule

// File: tb/tb_debounced_updown_display.sv
// tb_debounced_updown_display: table-driven, directed and randomized checks against a reference model
module tb_debounced_updown_display;
  localparam int DIGITS = 2, DT = 4, RD = 20, RATE = 8, REF = 4;
  localparam int MAXV = 99;

  typedef struct {
    bit up;
    bit wr;
    int n;
    logic [7:0] exp;
    int lims;
  } vec_t;

  logic clk = 0, reset = 0, sw = 0, uphdnl = 1, wrap_en = 0;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  logic [4*DIGITS-1:0] count;
  logic limit;

  int checks = 0, failures = 0, lim_pulses = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  debounced_updown_display #(
    .DIGITS(DIGITS), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RATE), .REFRESH_TICKS(REF), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .uphdnl(uphdnl), .wrap_en(wrap_en),
    .seg(seg), .an(an), .count(count), .limit(limit)
  );

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = 4'((n / (10 ** i)) % 10);
    return r;
  endfunction

  // age = cycles since the debounced level rose; steps at 0, RD, RD+RATE, ...
  function automatic bit step_due(input bit db, input int age);
    return db && (age == 0 || (RD > 0 && age >= RD && (age - RD) % RATE == 0));
  endfunction

  function automatic int next_val(input int n, input bit up, input bit wr);
    if (up) return n == MAXV ? (wr ? 0 : MAXV) : n + 1;
    return n == 0 ? (wr ? MAXV : 0) : n - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit wr);
    uphdnl = up;
    wrap_en = wr;
    tick(3);
    sw = 1;
    tick(10);
    sw = 0;
    tick(10);
  endtask

  // reference model: decimal integer count, debounce as "last DT+1 synced samples disagree"
  int m_n = 0, m_prev = 0, m_age = 0, m_k = 0;
  bit m_db = 0, m_lim = 0;
  bit [1:0] m_sw = 0, m_dir = 0, m_wrap = 0;
  bit [DT:0] m_win = 0;

  always @(posedge clk)
    if (!reset) begin
      m_n <= 0; m_prev <= 0; m_age <= 0; m_k <= 0; m_db <= 0; m_lim <= 0;
      m_sw <= 0; m_dir <= 0; m_wrap <= 0; m_win <= 0;
    end else begin
      m_prev <= m_n;
      m_k <= m_k + 1;
      m_lim <= step_due(m_db, m_age) && (m_dir[1] ? m_n == MAXV : m_n == 0);
      if (step_due(m_db, m_age)) m_n <= next_val(m_n, m_dir[1], m_wrap[1]);
      m_win <= {m_win[DT-1:0], m_sw[1]};
      if ({m_win[DT-1:0], m_sw[1]} == {(DT+1){~m_db}}) begin
        m_db <= ~m_db;
        m_age <= 0;
      end else
        m_age <= m_age + 1;
      m_sw <= {m_sw[0], sw};
      m_dir <= {m_dir[0], uphdnl};
      m_wrap <= {m_wrap[0], wrap_en};
    end

  // continuous comparison against the model, half a cycle after each edge
  always @(negedge clk) begin
    int idx;
    logic [DIGITS-1:0] ea;
    logic [6:0] es;
    if (limit === 1'b1) lim_pulses++;
    if (chk_en) begin
      idx = (m_k / REF) % DIGITS;
      ea = ~(DIGITS'(1) << idx);
      es = (idx > 0 && m_prev < 10 ** idx) ? 7'b1111111 : enc((m_prev / (10 ** idx)) % 10);
      chk("model_count", 32'(count), 32'(to_bcd(m_n)));
      chk("model_limit", 32'(limit), 32'(m_lim));
      chk("model_an", 32'(an), 32'(ea));
      chk("model_seg", 32'(seg), 32'(es));
    end
  end

  vec_t tbl [12] = '{
    '{1'b1, 1'b0,  8, 8'h09, 0},
    '{1'b1, 1'b0,  1, 8'h10, 0},
    '{1'b0, 1'b0,  1, 8'h09, 0},
    '{1'b1, 1'b0, 90, 8'h99, 0},
    '{1'b1, 1'b1,  1, 8'h00, 1},
    '{1'b0, 1'b0,  1, 8'h00, 1},
    '{1'b0, 1'b1,  1, 8'h99, 1},
    '{1'b1, 1'b0,  1, 8'h99, 1},
    '{1'b0, 1'b1, 89, 8'h10, 0},
    '{1'b0, 1'b0,  1, 8'h09, 0},
    '{1'b1, 1'b1, 90, 8'h99, 0},
    '{1'b1, 1'b0,  3, 8'h99, 3}
  };

  int stp [5] = '{7, 27, 35, 43, 51};

  initial begin
    int lp0, e;
    // reset and scan
    tick(1);
    chk_en = 1;
    tick(2);
    reset = 1;
    chk("reset_count", 32'(count), 32'h00);
    chk("reset_limit", 32'(limit), 32'h0);
    chk("reset_an", 32'(an), 32'b10);
    chk("reset_seg", 32'(seg), 32'b0000001);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk("scan_an", 32'(an), (k % 8) < 4 ? 32'b10 : 32'b01);
      chk("scan_seg", 32'(seg), (k % 8) < 4 ? 32'b0000001 : 32'b1111111);
    end
    // glitch of 3 cycles is ignored
    uphdnl = 1;
    tick(3);
    sw = 1;
    tick(3);
    sw = 0;
    tick(12);
    chk("glitch_count", 32'(count), 32'h00);
    // clean press: count moves exactly 7 edges after sw is first sampled
    sw = 1;
    tick(7);
    chk("latency_before", 32'(count), 32'h00);
    tick(1);
    chk("latency_at", 32'(count), 32'h01);
    tick(2);
    sw = 0;
    tick(15);
    chk("release_count", 32'(count), 32'h01);
    // table of press runs: carry, borrow, wrap and saturate
    foreach (tbl[t]) begin
      lp0 = lim_pulses;
      for (int p = 0; p < tbl[t].n; p++) press(tbl[t].up, tbl[t].wr);
      chk($sformatf("tbl%0d_count", t), 32'(count), 32'(tbl[t].exp));
      chk($sformatf("tbl%0d_limits", t), lim_pulses - lp0, tbl[t].lims);
    end
    // auto-repeat: press step, then RD later, then every RATE, stop after release
    reset = 0;
    tick(1);
    reset = 1;
    uphdnl = 1;
    wrap_en = 0;
    tick(3);
    sw = 1;
    for (int k = 0; k <= 90; k++) begin
      tick(1);
      e = 0;
      foreach (stp[s]) if (k >= stp[s]) e++;
      chk("repeat_count", 32'(count), 32'(to_bcd(e)));
      if (k == 49) sw = 0;
    end
    // reset mid-repeat, then a fresh single press step with the delay restarted
    sw = 1;
    tick(31);
    reset = 0;
    tick(1);
    chk("midrst_count", 32'(count), 32'h00);
    chk("midrst_limit", 32'(limit), 32'h0);
    chk("midrst_an", 32'(an), 32'b10);
    chk("midrst_seg", 32'(seg), 32'b0000001);
    reset = 1;
    for (int k = 0; k <= 30; k++) begin
      tick(1);
      chk("after_rst_count", 32'(count), 32'((k >= 7 ? 1 : 0) + (k >= 27 ? 1 : 0)));
    end
    sw = 0;
    tick(20);
    // randomized stimulus, checked continuously against the model
    for (int r = 0; r < 160; r++) begin
      sw = 1'($urandom);
      uphdnl = 1'($urandom);
      wrap_en = 1'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        reset = 0;
        tick(1);
        reset = 1;
      end
      tick($urandom_range(1, 40));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
